button_conditioner: RTL and testbench

Front-end conditioning stage for the board's push-buttons. It sits between the raw button pins and the operand-loading controller. Each channel is synchronised into the clock domain and debounced by a per-channel counter FSM. Each channel then produces a clean level plus single-cycle press and release pulses. This lets the controller load one operand byte per physical press without a manual lock/unlock button.

---
 rtl/button_conditioner.sv | 160 ++++++++++++++++
 tb/tb_button_conditioner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions the raw push-button pins before they reach the operand-loading
// controller. Each channel is synchronised into the clk domain and debounced.
// It then provides a clean level plus one-cycle press and release pulses, so
// the controller can load exactly one operand per physical press.
//
// Parameters
//   N               number of independent button channels (>= 1)
//   DEBOUNCE_CYCLES cycles a new level must stay stable before it is accepted
//                   (>= 2; 500000 is 10 ms at 50 MHz)
//   CNT_W           debounce counter width; 2**CNT_W must exceed
//                   DEBOUNCE_CYCLES-1
//
// Ports
//   clk          in   1    system clock; all state updates on the rising edge
//   rst_n        in   1    asynchronous active-low reset
//   btn_raw      in   N    raw, asynchronous, bouncing levels (1 = pressed)
//   btn_level    out  N    debounced level per channel (registered)
//   btn_press    out  N    one-cycle pulse on an accepted 0->1 transition
//   btn_release  out  N    one-cycle pulse on an accepted 1->0 transition
//   state_dbg    out  2*N  debounce FSM state per channel; channel g occupies
//                          bits [2*g+1:2*g], encoded as state_t below
//
// Handshake: there is no valid/ready flow control. btn_level is a plain
// level. btn_press and btn_release are qualifying strobes, each valid for
// exactly the one cycle it is high. The consumer must sample them on every
// clock edge and cannot stall them.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N               = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   btn_raw,
    output logic [N-1:0]   btn_level,
    output logic [N-1:0]   btn_press,
    output logic [N-1:0]   btn_release,
    output logic [2*N-1:0] state_dbg
);

    // RELEASED / PRESSED are the stable states. The *_CHK states count how
    // long the opposite level has been held before it is accepted.
    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    // Terminal count. The check state is entered with cnt=0, and the edge
    // that sees cnt at this value (with the new level still present) accepts
    // it. That gives DEBOUNCE_CYCLES+1 consecutive qualifying samples at
    // sync2, counting the one that entered the check state.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar g = 0; g < N; g++) begin : g_ch

        logic              sync1;
        logic              sync2;
        state_t            state;
        logic [CNT_W-1:0]  cnt;
        logic              level_q;
        logic              press_q;
        logic              release_q;

        // Two-flop synchroniser. btn_raw is asynchronous, so only sync2 is
        // allowed to influence the FSM.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= btn_raw[g];
                sync2 <= sync1;
            end
        end

        // Debounce FSM with registered outputs. The pulses default low on
        // every edge, so a pulse can never last longer than one cycle. The
        // counter is cleared on every state exit, so it never wraps: the
        // largest value it reaches is CNT_LAST.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= RELEASED;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;

                case (state)
                    RELEASED: begin
                        if (sync2) begin
                            state <= PRESS_CHK;
                            cnt   <= '0;
                        end
                    end

                    PRESS_CHK: begin
                        if (!sync2) begin
                            // Bounce back to the released level: start over
                            // without emitting anything.
                            state <= RELEASED;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    PRESSED: begin
                        if (!sync2) begin
                            state <= RELEASE_CHK;
                            cnt   <= '0;
                        end
                    end

                    RELEASE_CHK: begin
                        if (sync2) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state     <= RELEASED;
                            cnt       <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    default: begin
                        // Recovery from a corrupted state register: fall
                        // back to the released state silently.
                        state   <= RELEASED;
                        cnt     <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_level[g]         = level_q;
        assign btn_press[g]         = press_q;
        assign btn_release[g]       = release_q;
        assign state_dbg[2*g +: 2]  = state;

    end : g_ch

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner with N=2 and DEBOUNCE_CYCLES=4.
//
// Reference model: for each channel, the bench tracks the accepted level and
// the length of the current run of sync2 samples that disagree with it. sync2
// is the raw input delayed by two edges. When the run reaches
// DEBOUNCE_CYCLES+1 samples, the level flips and the matching pulse is
// expected. Any agreeing sample clears the run.
//
// Each driven edge pushes the expected {level, press, release} vector into
// exp_q. A monitor pops one entry on every edge and compares it with the DUT.
// Directed scenarios also check pulse latencies and counts against fixed
// values.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N     = 2;
    localparam int D     = 4;
    localparam int CNT_W = 3;
    localparam int W     = 3 * N;

    // ---------------------------------------------------------------- clock/reset
    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   btn_raw = '1;
    logic [N-1:0]   btn_level;
    logic [N-1:0]   btn_press;
    logic [N-1:0]   btn_release;
    logic [2*N-1:0] state_dbg;

    always #5 clk = ~clk;

    button_conditioner #(
        .N               (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .state_dbg   (state_dbg)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- scoreboard
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check_vec(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected vector per rising edge, compared just after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check_vec("outputs", {btn_level, btn_press, btn_release}, e);
            check_vec("press_release_exclusive", W'(btn_press & btn_release), '0);
        end
    end

    // ---------------------------------------------------------------- reference model
    logic [N-1:0] m_pipe1;
    logic [N-1:0] m_pipe2;
    logic [N-1:0] m_level;
    int           m_run[N];

    function automatic void model_reset();
        m_pipe1 = '0;
        m_pipe2 = '0;
        m_level = '0;
        for (int ch = 0; ch < N; ch++) m_run[ch] = 0;
    endfunction

    // Advance the model by one edge sampling raw, and queue the outputs
    // expected just after that edge.
    function automatic void model_edge(input logic [N-1:0] raw);
        logic [N-1:0] seen;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        seen    = m_pipe2;
        m_pipe2 = m_pipe1;
        m_pipe1 = raw;
        press   = '0;
        rel     = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (seen[ch] != m_level[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == D + 1) begin
                    m_level[ch] = seen[ch];
                    m_run[ch]   = 0;
                    if (seen[ch]) press[ch] = 1'b1;
                    else          rel[ch]   = 1'b1;
                end
            end else begin
                m_run[ch] = 0;
            end
        end
        exp_q.push_back({m_level, press, rel});
    endfunction

    // ---------------------------------------------------------------- driver tasks
    // Per-scenario observations, indexed by edge number since the last mark().
    int t;
    int press_at[N];
    int rel_at[N];
    int press_cnt[N];
    int rel_cnt[N];
    int level_seen[N];

    task automatic mark();
        t = 0;
        for (int ch = 0; ch < N; ch++) begin
            press_at[ch]   = -1;
            rel_at[ch]     = -1;
            press_cnt[ch]  = 0;
            rel_cnt[ch]    = 0;
            level_seen[ch] = 0;
        end
    endtask

    // Called at a falling edge: drive raw, expect one rising edge, and return
    // at the next falling edge.
    task automatic step(input logic [N-1:0] raw);
        btn_raw = raw;
        model_edge(raw);
        @(posedge clk);
        #2;
        for (int ch = 0; ch < N; ch++) begin
            if (btn_press[ch]) begin
                press_cnt[ch]++;
                if (press_at[ch] < 0) press_at[ch] = t;
            end
            if (btn_release[ch]) begin
                rel_cnt[ch]++;
                if (rel_at[ch] < 0) rel_at[ch] = t;
            end
            if (btn_level[ch]) level_seen[ch] = 1;
        end
        t++;
        @(negedge clk);
    endtask

    task automatic hold(input logic [N-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw);
    endtask

    // Called at a falling edge; btn_raw keeps its current value.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        check_vec("reset_async_drop", {btn_level, btn_press, btn_release}, '0);
        model_reset();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('0);
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- stimulus
    int pat[13] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        model_reset();
        @(negedge clk);

        // Reset with both buttons already held.
        btn_raw = 2'b11;
        do_reset(3);
        mark();
        hold(2'b11, 10);
        check_int("reset_hold_press0_edge", press_at[0], 6);
        check_int("reset_hold_press1_edge", press_at[1], 6);
        check_int("reset_hold_press0_count", press_cnt[0], 1);
        check_int("reset_hold_press1_count", press_cnt[1], 1);

        mark();
        hold(2'b00, 10);
        check_int("release_both_edge0", rel_at[0], 6);
        check_int("release_both_edge1", rel_at[1], 6);

        // Clean press and release on ch0.
        mark();
        hold(2'b01, 10);
        check_int("clean_press0_edge", press_at[0], 6);
        check_int("clean_press0_count", press_cnt[0], 1);
        check_int("clean_ch1_quiet", press_cnt[1] + level_seen[1], 0);
        mark();
        hold(2'b00, 10);
        check_int("clean_release0_edge", rel_at[0], 6);
        check_int("clean_release0_count", rel_cnt[0], 1);

        // Bounce: the last 0 is at edge 4, so acceptance is at edge 5+6=11.
        mark();
        for (int i = 0; i < 13; i++) step(N'(pat[i]));
        hold(2'b01, 4);
        check_int("bounce_press0_count", press_cnt[0], 1);
        check_int("bounce_press0_edge", press_at[0], 11);
        check_int("bounce_release0_count", rel_cnt[0], 0);
        hold(2'b00, 10);

        // Three-cycle glitch on ch1: too short to qualify.
        mark();
        hold(2'b10, 3);
        hold(2'b00, 8);
        check_int("glitch_press1_count", press_cnt[1], 0);
        check_int("glitch_release1_count", rel_cnt[1], 0);
        check_int("glitch_level1_seen", level_seen[1], 0);

        // Independence: ch0 at edge 0, ch1 at edge 2.
        mark();
        hold(2'b01, 2);
        hold(2'b11, 10);
        check_int("indep_press0_edge", press_at[0], 6);
        check_int("indep_press1_edge", press_at[1], 8);
        check_int("indep_press0_count", press_cnt[0], 1);
        check_int("indep_press1_count", press_cnt[1], 1);

        // Reset while both channels are pressed and still held.
        do_reset(3);
        mark();
        hold(2'b11, 10);
        check_int("midreset_press0_edge", press_at[0], 6);
        check_int("midreset_press1_edge", press_at[1], 6);
        check_int("midreset_release_count", rel_cnt[0] + rel_cnt[1], 0);
        hold(2'b00, 10);

        // Randomised holds of random length, with occasional resets.
        for (int i = 0; i < 80; i++) begin
            hold(N'($urandom_range(0, 3)), $urandom_range(1, 10));
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
        end

        hold(2'b00, 12);
        @(negedge clk);
        @(negedge clk);
        check_int("queue_drained", exp_q.size(), 0);
        check_int("state_dbg_known", int'($isunknown(state_dbg)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
